// File: rtl/mix_columns_stage.sv
// AES MixColumns pipeline stage: COLS_PER_CYCLE columns mixed per clock, with a key and Rcon pass-through.
// Optional macro MIXCOL_LAST_ROUND_EN adds a last_round input that bypasses the mix.
module mix_columns_stage #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clock,
    input  logic       reset_n,
`ifdef MIXCOL_LAST_ROUND_EN
    input  logic       last_round,
`endif
    input  logic [7:0] S0,
    input  logic [7:0] S1,
    input  logic [7:0] S2,
    input  logic [7:0] S3,
    input  logic [7:0] S4,
    input  logic [7:0] S5,
    input  logic [7:0] S6,
    input  logic [7:0] S7,
    input  logic [7:0] S8,
    input  logic [7:0] S9,
    input  logic [7:0] SA,
    input  logic [7:0] SB,
    input  logic [7:0] SC,
    input  logic [7:0] SD,
    input  logic [7:0] SE,
    input  logic [7:0] SF,
    input  logic [7:0] K0,
    input  logic [7:0] K1,
    input  logic [7:0] K2,
    input  logic [7:0] K3,
    input  logic [7:0] K4,
    input  logic [7:0] K5,
    input  logic [7:0] K6,
    input  logic [7:0] K7,
    input  logic [7:0] K8,
    input  logic [7:0] K9,
    input  logic [7:0] KA,
    input  logic [7:0] KB,
    input  logic [7:0] KC,
    input  logic [7:0] KD,
    input  logic [7:0] KE,
    input  logic [7:0] KF,
    input  logic [7:0] Rcon_in,
    input  logic       empty_in,
    output logic       in_ready,
    input  logic       out_ready,
    output logic [7:0] G0,
    output logic [7:0] G1,
    output logic [7:0] G2,
    output logic [7:0] G3,
    output logic [7:0] G4,
    output logic [7:0] G5,
    output logic [7:0] G6,
    output logic [7:0] G7,
    output logic [7:0] G8,
    output logic [7:0] G9,
    output logic [7:0] GA,
    output logic [7:0] GB,
    output logic [7:0] GC,
    output logic [7:0] GD,
    output logic [7:0] GE,
    output logic [7:0] GF,
    output logic [7:0] KO0,
    output logic [7:0] KO1,
    output logic [7:0] KO2,
    output logic [7:0] KO3,
    output logic [7:0] KO4,
    output logic [7:0] KO5,
    output logic [7:0] KO6,
    output logic [7:0] KO7,
    output logic [7:0] KO8,
    output logic [7:0] KO9,
    output logic [7:0] KOA,
    output logic [7:0] KOB,
    output logic [7:0] KOC,
    output logic [7:0] KOD,
    output logic [7:0] KOE,
    output logic [7:0] KOF,
    output logic [7:0] Rcon_out,
    output logic       empty
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_stage: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // A 2-bit pointer wraps naturally; with 4 columns per cycle the step is 0 and the pointer stays at 0.
    localparam logic [1:0] PTR_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_PTR = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] st_reg    [16];
    logic [7:0] key_reg   [16];
    logic [7:0] rcon_reg;
    logic       empty_reg;
    logic [7:0] s_in      [16];
    logic [7:0] k_in      [16];
    logic [7:0] mixed     [16];
    logic       accept;
    logic       skip_mix;

    assign s_in[0]  = S0;  assign s_in[1]  = S1;  assign s_in[2]  = S2;  assign s_in[3]  = S3;
    assign s_in[4]  = S4;  assign s_in[5]  = S5;  assign s_in[6]  = S6;  assign s_in[7]  = S7;
    assign s_in[8]  = S8;  assign s_in[9]  = S9;  assign s_in[10] = SA;  assign s_in[11] = SB;
    assign s_in[12] = SC;  assign s_in[13] = SD;  assign s_in[14] = SE;  assign s_in[15] = SF;

    assign k_in[0]  = K0;  assign k_in[1]  = K1;  assign k_in[2]  = K2;  assign k_in[3]  = K3;
    assign k_in[4]  = K4;  assign k_in[5]  = K5;  assign k_in[6]  = K6;  assign k_in[7]  = K7;
    assign k_in[8]  = K8;  assign k_in[9]  = K9;  assign k_in[10] = KA;  assign k_in[11] = KB;
    assign k_in[12] = KC;  assign k_in[13] = KD;  assign k_in[14] = KE;  assign k_in[15] = KF;

    assign G0 = st_reg[0];   assign G1 = st_reg[1];   assign G2 = st_reg[2];   assign G3 = st_reg[3];
    assign G4 = st_reg[4];   assign G5 = st_reg[5];   assign G6 = st_reg[6];   assign G7 = st_reg[7];
    assign G8 = st_reg[8];   assign G9 = st_reg[9];   assign GA = st_reg[10];  assign GB = st_reg[11];
    assign GC = st_reg[12];  assign GD = st_reg[13];  assign GE = st_reg[14];  assign GF = st_reg[15];

    assign KO0 = key_reg[0];   assign KO1 = key_reg[1];   assign KO2 = key_reg[2];   assign KO3 = key_reg[3];
    assign KO4 = key_reg[4];   assign KO5 = key_reg[5];   assign KO6 = key_reg[6];   assign KO7 = key_reg[7];
    assign KO8 = key_reg[8];   assign KO9 = key_reg[9];   assign KOA = key_reg[10];  assign KOB = key_reg[11];
    assign KOC = key_reg[12];  assign KOD = key_reg[13];  assign KOE = key_reg[14];  assign KOF = key_reg[15];

    assign Rcon_out = rcon_reg;
    assign empty    = empty_reg;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_ready && !empty_in;

`ifdef MIXCOL_LAST_ROUND_EN
    assign skip_mix = last_round;
`else
    assign skip_mix = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    endfunction

    // Column packed row 0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]  col_idx;
    logic [31:0] col_in;
    logic [31:0] col_out;

    always_comb begin
        mixed   = st_reg;
        col_idx = '0;
        col_in  = '0;
        col_out = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_idx = ptr + 2'(j);
            col_in  = {st_reg[{col_idx, 2'd0}], st_reg[{col_idx, 2'd1}],
                       st_reg[{col_idx, 2'd2}], st_reg[{col_idx, 2'd3}]};
            col_out = mix_column(col_in);
            mixed[{col_idx, 2'd0}] = col_out[31:24];
            mixed[{col_idx, 2'd1}] = col_out[23:16];
            mixed[{col_idx, 2'd2}] = col_out[15:8];
            mixed[{col_idx, 2'd3}] = col_out[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            rcon_reg  <= '0;
            empty_reg <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                st_reg[i]  <= '0;
                key_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        st_reg   <= s_in;
                        key_reg  <= k_in;
                        rcon_reg <= Rcon_in;
                        ptr      <= '0;
                        if (skip_mix) begin
                            state     <= DONE;
                            empty_reg <= 1'b0;
                        end else begin
                            state     <= MIX;
                            empty_reg <= 1'b1;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        empty_reg <= 1'b1;
                    end
                end
                MIX: begin
                    st_reg <= mixed;
                    ptr    <= ptr + PTR_STEP;
                    if (ptr == LAST_PTR) begin
                        state     <= DONE;
                        empty_reg <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    empty_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_stage.sv
// Directed bench for mix_columns_stage: one instance mixing 1 column per cycle, one mixing 4.
// Build with MIXCOL_LAST_ROUND_EN defined to also exercise the last-round bypass.
module tb_mix_columns_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic [127:0] sBus, kBus;
    logic [7:0]   rconIn;
    logic         emptyIn1, emptyIn4, outReady, lastRound;
    logic         inReady1, inReady4, empty1, empty4;
    logic [127:0] g1, g4, ko1, ko4;
    logic [7:0]   rcon1, rcon4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic [7:0]   rcon;
        logic [127:0] g;
    } vecT;

    vecT vec[4];

    mix_columns_stage #(.COLS_PER_CYCLE(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
`ifdef MIXCOL_LAST_ROUND_EN
        .last_round(lastRound),
`endif
        .S0(sBus[127:120]), .S1(sBus[119:112]), .S2(sBus[111:104]), .S3(sBus[103:96]),
        .S4(sBus[95:88]),   .S5(sBus[87:80]),   .S6(sBus[79:72]),   .S7(sBus[71:64]),
        .S8(sBus[63:56]),   .S9(sBus[55:48]),   .SA(sBus[47:40]),   .SB(sBus[39:32]),
        .SC(sBus[31:24]),   .SD(sBus[23:16]),   .SE(sBus[15:8]),    .SF(sBus[7:0]),
        .K0(kBus[127:120]), .K1(kBus[119:112]), .K2(kBus[111:104]), .K3(kBus[103:96]),
        .K4(kBus[95:88]),   .K5(kBus[87:80]),   .K6(kBus[79:72]),   .K7(kBus[71:64]),
        .K8(kBus[63:56]),   .K9(kBus[55:48]),   .KA(kBus[47:40]),   .KB(kBus[39:32]),
        .KC(kBus[31:24]),   .KD(kBus[23:16]),   .KE(kBus[15:8]),    .KF(kBus[7:0]),
        .Rcon_in(rconIn), .empty_in(emptyIn1), .in_ready(inReady1), .out_ready(outReady),
        .G0(g1[127:120]), .G1(g1[119:112]), .G2(g1[111:104]), .G3(g1[103:96]),
        .G4(g1[95:88]),   .G5(g1[87:80]),   .G6(g1[79:72]),   .G7(g1[71:64]),
        .G8(g1[63:56]),   .G9(g1[55:48]),   .GA(g1[47:40]),   .GB(g1[39:32]),
        .GC(g1[31:24]),   .GD(g1[23:16]),   .GE(g1[15:8]),    .GF(g1[7:0]),
        .KO0(ko1[127:120]), .KO1(ko1[119:112]), .KO2(ko1[111:104]), .KO3(ko1[103:96]),
        .KO4(ko1[95:88]),   .KO5(ko1[87:80]),   .KO6(ko1[79:72]),   .KO7(ko1[71:64]),
        .KO8(ko1[63:56]),   .KO9(ko1[55:48]),   .KOA(ko1[47:40]),   .KOB(ko1[39:32]),
        .KOC(ko1[31:24]),   .KOD(ko1[23:16]),   .KOE(ko1[15:8]),    .KOF(ko1[7:0]),
        .Rcon_out(rcon1), .empty(empty1)
    );

    mix_columns_stage #(.COLS_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset_n(reset_n),
`ifdef MIXCOL_LAST_ROUND_EN
        .last_round(1'b0),
`endif
        .S0(sBus[127:120]), .S1(sBus[119:112]), .S2(sBus[111:104]), .S3(sBus[103:96]),
        .S4(sBus[95:88]),   .S5(sBus[87:80]),   .S6(sBus[79:72]),   .S7(sBus[71:64]),
        .S8(sBus[63:56]),   .S9(sBus[55:48]),   .SA(sBus[47:40]),   .SB(sBus[39:32]),
        .SC(sBus[31:24]),   .SD(sBus[23:16]),   .SE(sBus[15:8]),    .SF(sBus[7:0]),
        .K0(kBus[127:120]), .K1(kBus[119:112]), .K2(kBus[111:104]), .K3(kBus[103:96]),
        .K4(kBus[95:88]),   .K5(kBus[87:80]),   .K6(kBus[79:72]),   .K7(kBus[71:64]),
        .K8(kBus[63:56]),   .K9(kBus[55:48]),   .KA(kBus[47:40]),   .KB(kBus[39:32]),
        .KC(kBus[31:24]),   .KD(kBus[23:16]),   .KE(kBus[15:8]),    .KF(kBus[7:0]),
        .Rcon_in(rconIn), .empty_in(emptyIn4), .in_ready(inReady4), .out_ready(outReady),
        .G0(g4[127:120]), .G1(g4[119:112]), .G2(g4[111:104]), .G3(g4[103:96]),
        .G4(g4[95:88]),   .G5(g4[87:80]),   .G6(g4[79:72]),   .G7(g4[71:64]),
        .G8(g4[63:56]),   .G9(g4[55:48]),   .GA(g4[47:40]),   .GB(g4[39:32]),
        .GC(g4[31:24]),   .GD(g4[23:16]),   .GE(g4[15:8]),    .GF(g4[7:0]),
        .KO0(ko4[127:120]), .KO1(ko4[119:112]), .KO2(ko4[111:104]), .KO3(ko4[103:96]),
        .KO4(ko4[95:88]),   .KO5(ko4[87:80]),   .KO6(ko4[79:72]),   .KO7(ko4[71:64]),
        .KO8(ko4[63:56]),   .KO9(ko4[55:48]),   .KOA(ko4[47:40]),   .KOB(ko4[39:32]),
        .KOC(ko4[31:24]),   .KOD(ko4[23:16]),   .KOE(ko4[15:8]),    .KOF(ko4[7:0]),
        .Rcon_out(rcon4), .empty(empty4)
    );

    function automatic logic [127:0] gOf(input int which);
        return (which == 4) ? g4 : g1;
    endfunction

    function automatic logic [127:0] koOf(input int which);
        return (which == 4) ? ko4 : ko1;
    endfunction

    function automatic logic [7:0] rconOf(input int which);
        return (which == 4) ? rcon4 : rcon1;
    endfunction

    function automatic logic emptyOf(input int which);
        return (which == 4) ? empty4 : empty1;
    endfunction

    function automatic logic inReadyOf(input int which);
        return (which == 4) ? inReady4 : inReady1;
    endfunction

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int which, input int v);
        checkVal($sformatf("dut%0d_G_v%0d", which, v), gOf(which), vec[v].g);
        checkVal($sformatf("dut%0d_KO_v%0d", which, v), koOf(which), vec[v].k);
        checkVal($sformatf("dut%0d_rcon_v%0d", which, v), 128'(rconOf(which)), 128'(vec[v].rcon));
    endtask

    task automatic applyStimulus(input int which, input int v);
        @(negedge clock);
        sBus   = vec[v].s;
        kBus   = vec[v].k;
        rconIn = vec[v].rcon;
        if (which == 4) emptyIn4 = 1'b0;
        else            emptyIn1 = 1'b0;
    endtask

    // Counts edges after the accept edge until empty drops; a budget of 20 edges bounds the wait.
    task automatic waitDone(input int which, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (emptyOf(which) && n < 20);
    endtask

    task automatic runBlock(input int which, input int v, input int expEdges);
        int n;
        outReady = 1'b1;
        applyStimulus(which, v);
        @(posedge clock);
        #1;
        if (which == 4) emptyIn4 = 1'b1;
        else            emptyIn1 = 1'b1;
        checkVal($sformatf("dut%0d_busy_empty_v%0d", which, v), 128'(emptyOf(which)), 128'd1);
        checkVal($sformatf("dut%0d_busy_in_ready_v%0d", which, v), 128'(inReadyOf(which)), 128'd0);
        waitDone(which, n);
        checkVal($sformatf("dut%0d_latency_v%0d", which, v), 128'(n), 128'(expEdges));
        checkOutput(which, v);
        @(posedge clock);
        #1;
        checkVal($sformatf("dut%0d_idle_empty_v%0d", which, v), 128'(emptyOf(which)), 128'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;

        vec[0] = '{s: 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                   k: 128'h00010203_04050607_08090a0b_0c0d0e0f, rcon: 8'h01,
                   g: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vec[1] = '{s: 128'hd4d4d4d5_2d26314c_00000000_80808080,
                   k: 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, rcon: 8'h1b,
                   g: 128'hd5d5d7d6_4d7ebdf8_00000000_80808080};
        vec[2] = '{s: 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                   k: 128'ha0fafe17_88542cb1_23a33939_2a6c7605, rcon: 8'h02,
                   g: 128'h046681e5_e0cb199a_48f8d37a_2806264c};
        vec[3] = '{s: 128'h2d26314c_d4bf5d30_c6c6c6c6_db135345,
                   k: 128'hffeeddcc_bbaa9988_77665544_33221100, rcon: 8'h36,
                   g: 128'h4d7ebdf8_046681e5_c6c6c6c6_8e4da1bc};

        sBus      = '0;
        kBus      = '0;
        rconIn    = '0;
        emptyIn1  = 1'b1;
        emptyIn4  = 1'b1;
        outReady  = 1'b1;
        lastRound = 1'b0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        #10;
        for (int w = 1; w <= 4; w += 3) begin
            checkVal($sformatf("dut%0d_reset_empty", w), 128'(emptyOf(w)), 128'd1);
            checkVal($sformatf("dut%0d_reset_G", w), gOf(w), 128'd0);
            checkVal($sformatf("dut%0d_reset_KO", w), koOf(w), 128'd0);
            checkVal($sformatf("dut%0d_reset_rcon", w), 128'(rconOf(w)), 128'd0);
            checkVal($sformatf("dut%0d_reset_in_ready", w), 128'(inReadyOf(w)), 128'd1);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;

        for (int v = 0; v < 4; v++) runBlock(1, v, 4);

        runBlock(4, 1, 1);
        runBlock(4, 2, 1);
        runBlock(4, 3, 1);

        // Result held in DONE while downstream stalls; a waiting block must not be taken.
        outReady = 1'b0;
        applyStimulus(1, 0);
        @(posedge clock);
        #1 emptyIn1 = 1'b1;
        waitDone(1, n);
        checkVal("hold_latency", 128'(n), 128'd4);
        sBus     = vec[2].s;
        kBus     = vec[2].k;
        rconIn   = vec[2].rcon;
        emptyIn1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            checkVal($sformatf("hold_G_c%0d", c), g1, vec[0].g);
            checkVal($sformatf("hold_in_ready_c%0d", c), 128'(inReady1), 128'd0);
        end
        checkVal("hold_empty", 128'(empty1), 128'd0);
        checkVal("hold_KO", ko1, vec[0].k);

        // Release the stall with the next block already waiting: back-to-back accept.
        @(negedge clock);
        outReady = 1'b1;
        @(posedge clock);
        #1 emptyIn1 = 1'b1;
        checkVal("b2b_empty", 128'(empty1), 128'd1);
        checkVal("b2b_KO", ko1, vec[2].k);
        waitDone(1, n);
        checkVal("b2b_latency", 128'(n), 128'd4);
        checkOutput(1, 2);
        @(posedge clock);
        #1;
        checkVal("b2b_idle_empty", 128'(empty1), 128'd1);

        // Reset in the middle of a mix, after two columns.
        applyStimulus(1, 3);
        @(posedge clock);
        #1 emptyIn1 = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        checkVal("midreset_empty", 128'(empty1), 128'd1);
        checkVal("midreset_G", g1, 128'd0);
        checkVal("midreset_KO", ko1, 128'd0);
        checkVal("midreset_in_ready", 128'(inReady1), 128'd1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkVal("postreset_empty", 128'(empty1), 128'd1);
        checkVal("postreset_G", g1, 128'd0);
        runBlock(1, 3, 4);

`ifdef MIXCOL_LAST_ROUND_EN
        @(negedge clock);
        sBus      = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        kBus      = vec[0].k;
        rconIn    = vec[0].rcon;
        lastRound = 1'b1;
        emptyIn1  = 1'b0;
        @(posedge clock);
        #1;
        emptyIn1  = 1'b1;
        lastRound = 1'b0;
        checkVal("last_round_empty", 128'(empty1), 128'd0);
        checkVal("last_round_G", g1, 128'h00010203_04050607_08090a0b_0c0d0e0f);
        checkVal("last_round_KO", ko1, vec[0].k);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_stage.md
MIX_COLUMNS_STAGE -- requirements
Module: mix_columns_stage

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, meaning: columns mixed per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 S0..SF  input  8 each  state bytes from SubBytes/ShiftRows; column c = S(4c)..S(4c+3), row 0 first.
REQ-005 K0..KF  input  8 each  round-key bytes travelling with the block.
REQ-006 Rcon_in  input  8  round constant travelling with the block.
REQ-007 empty_in  input  1  1 = bubble, 0 = valid block on S/K/Rcon_in.
REQ-008 in_ready  output  1  1 = block accepted at this edge when empty_in=0.
REQ-009 out_ready  input  1  downstream AddroundKey can take the block.
REQ-010 G0..GF  output  8 each  mixed state bytes to AddroundKey, same byte order as S.
REQ-011 KO0..KOF  output  8 each  registered copy of K0..KF for the captured block.
REQ-012 Rcon_out  output  8  registered copy of Rcon_in.
REQ-013 empty  output  1  0 = G/KO/Rcon_out hold a completed block.

Function
REQ-014 FSM states: IDLE, MIX, DONE; in_ready SHALL be combinational = (IDLE) or (DONE and out_ready).
REQ-015 Accept = in_ready and not empty_in; on accept, S, K, Rcon_in SHALL be registered, column pointer cleared, next state MIX.
REQ-016 In MIX each edge SHALL replace COLS_PER_CYCLE columns in place, starting at the pointer, then advance the pointer by COLS_PER_CYCLE.
REQ-017 Per column: r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3, all in GF(2^8).
REQ-018 2x SHALL be (x<<1) truncated to 8 bits, XOR 0x1B when x[7]=1; 3x = 2x^x.
REQ-019 After the edge that mixes column 3, state SHALL be DONE; empty SHALL go 0 exactly 4/COLS_PER_CYCLE edges after the accept edge.
REQ-020 In DONE, G/KO/Rcon_out SHALL hold stable while out_ready=0; inputs SHALL be ignored.
REQ-021 DONE with out_ready=1 and empty_in=1 SHALL go to IDLE, empty=1 next cycle.
REQ-022 DONE with out_ready=1 and empty_in=0 SHALL accept the new block on the same edge (go to MIX, no IDLE bubble).
REQ-023 While in MIX, empty SHALL be 1; G SHALL show the partially mixed register content, not valid data.
REQ-024 Pointer SHALL wrap to 0 on accept; it SHALL never index beyond column 3.

Reset
REQ-025 reset_n=0 SHALL force, asynchronously: state IDLE, pointer 0, G0..GF=0, KO0..KOF=0, Rcon_out=0, empty=1.
REQ-026 Reset asserted in MIX or DONE SHALL discard the block; no partial output after release.
REQ-027 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MIXCOL_LAST_ROUND_EN: when defined, a 1-bit input last_round SHALL exist, sampled on accept.
REQ-029 With macro defined and last_round=1, the block SHALL skip MIX, go directly to DONE with G = captured S, empty=0 one edge after accept.
REQ-030 Without the macro, last_round SHALL not exist and every block SHALL be mixed.

Verification
REQ-031 COLS_PER_CYCLE=1, columns db135345, f20a225c, 01010101, c6c6c6c6, empty_in=0 one cycle, out_ready=1 -> empty=0 4 edges later, G columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6, KO=K, Rcon_out=Rcon_in.
REQ-032 COLS_PER_CYCLE=4, columns d4d4d4d5, 2d26314c, 00000000, 80808080 -> empty=0 1 edge after accept, G columns d5d5d7d6, 4d7ebdf8, 00000000, 80808080 (xtime 0x80=0x1B).
REQ-033 Block in DONE, out_ready=0 for 10 cycles, new block on S with empty_in=0 -> G/empty stable, in_ready=0, new block not captured.
REQ-034 DONE, out_ready=1, empty_in=0 same edge -> new block captured, empty=1 next cycle, second result after 4 edges.
REQ-035 reset_n pulsed low during MIX (after 2 columns) -> immediate empty=1, G=0, in_ready=1; next block mixes correctly.
REQ-036 MIXCOL_LAST_ROUND_EN defined, last_round=1, S=00..0F -> G=00..0F one edge after accept, empty=0.
